// File: rtl/people_pkg.sv
// Shared sprite constants, player-facing encoding and the sprite-sheet address helper.
// The movement controller uses the same LEFT_DIR/RIGHT_DIR values.
package people_pkg;

  localparam logic LEFT_DIR  = 1'b0;
  localparam logic RIGHT_DIR = 1'b1;

  localparam int unsigned SPRITE_W    = 20;
  localparam int unsigned SPRITE_H    = 20;
  localparam int unsigned ANIM_FRAMES = 4;
  localparam int unsigned FRAME_WORDS = 400;

  localparam logic [11:0] TRANSPARENT = 12'h0F0;

  // Player position and facing as latched once per frame.
  typedef struct packed {
    logic [9:0] left;
    logic [9:0] up;
    logic       dir;
  } people_pos_t;

  // frame*400 + row*20 + col as shift-adds: 400 = 256+128+16, 20 = 16+4.
  function automatic logic [10:0] sprite_addr(input logic [1:0]  frame,
                                              input logic [10:0] row,
                                              input logic [10:0] col);
    logic [10:0] f;
    f = {9'd0, frame};
    return (f << 8) + (f << 7) + (f << 4) + (row << 4) + (row << 2) + col;
  endfunction

endpackage

// File: rtl/people_sprite_render_if.sv
// Pixel-scan, player-state and sprite-ROM signals shared by the renderer and its neighbours.
interface people_sprite_render_if;

  logic        pix_en;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [9:0]  people_left;
  logic [9:0]  people_up;
  logic        dir;
  logic        freeze;
  logic [11:0] rom_data;
  logic [10:0] rom_addr;
  logic        sprite_on;
  logic [11:0] pixel_out;

  modport master (
    output pix_en, x, y, people_left, people_up, dir, freeze, rom_data,
    input  rom_addr, sprite_on, pixel_out
  );

  modport slave (
    input  pix_en, x, y, people_left, people_up, dir, freeze, rom_data,
    output rom_addr, sprite_on, pixel_out
  );

endinterface

// File: rtl/people_anim_ctrl.sv
// Once-per-frame position latch, movement detect and walk-cycle frame counter.
module people_anim_ctrl
  import people_pkg::*;
#(
  parameter int unsigned ANIM_DIV   = 8,
  parameter int unsigned FRAME_LINE = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] people_left,
  input  logic [9:0] people_up,
  input  logic       dir,
  input  logic       freeze,
  output logic [9:0] pos_l,
  output logic [9:0] pos_u,
  output logic       dir_l,
  output logic [1:0] frame_idx
);

  localparam int unsigned DivW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(ANIM_DIV - 1);

  people_pos_t     pos_q;
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]      frame_q, frame_d;
  logic            fb;
  logic            moving;

  assign fb     = pix_en && (x == 10'd0) && (y == 10'(FRAME_LINE));
  // Facing changes alone do not count as walking.
  assign moving = (people_left != pos_q.left) || (people_up != pos_q.up);

  always_comb begin
    div_cnt_d = div_cnt_q;
    frame_d   = frame_q;
    if (fb && !freeze) begin
      if (!moving) begin
        div_cnt_d = '0;
        frame_d   = 2'd0;
      end else if (div_cnt_q == DivLast) begin
        div_cnt_d = '0;
        frame_d   = frame_q + 2'd1;
      end else begin
        div_cnt_d = div_cnt_q + DivW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_q     <= '{left: 10'd320, up: 10'd240, dir: LEFT_DIR};
      div_cnt_q <= '0;
      frame_q   <= 2'd0;
    end else begin
      if (fb) begin
        pos_q <= '{left: people_left, up: people_up, dir: dir};
      end
      div_cnt_q <= div_cnt_d;
      frame_q   <= frame_d;
    end
  end

  assign pos_l     = pos_q.left;
  assign pos_u     = pos_q.up;
  assign dir_l     = pos_q.dir;
  assign frame_idx = frame_q;

endmodule

// File: rtl/people_sprite_render.sv
// Player sprite renderer: hit test, mirrored sheet addressing and a 3-clk pixel pipeline
// around an external synchronous sprite ROM, with colour-key transparency.
module people_sprite_render
  import people_pkg::*;
#(
  parameter int unsigned ANIM_DIV    = 8,
  parameter int unsigned FRAME_LINE  = 480,
  parameter logic [11:0] TRANSPARENT = 12'h0F0
) (
  input logic                   clk,
  input logic                   rst_n,
  people_sprite_render_if.slave bus
);

  logic [9:0]  pos_l;
  logic [9:0]  pos_u;
  logic        dir_l;
  logic [1:0]  frame_idx;

  logic [10:0] x11, y11, l11, u11;
  logic [10:0] col, row, col_m;
  logic [10:0] addr;
  logic        hit;
  logic        opaque;

  logic [10:0] rom_addr_q;
  logic        hit_d1_q, hit_d2_q;
  logic        sprite_on_q;
  logic [11:0] pixel_q;

  people_anim_ctrl #(
    .ANIM_DIV   (ANIM_DIV),
    .FRAME_LINE (FRAME_LINE)
  ) u_anim (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (bus.pix_en),
    .x           (bus.x),
    .y           (bus.y),
    .people_left (bus.people_left),
    .people_up   (bus.people_up),
    .dir         (bus.dir),
    .freeze      (bus.freeze),
    .pos_l       (pos_l),
    .pos_u       (pos_u),
    .dir_l       (dir_l),
    .frame_idx   (frame_idx)
  );

  // 11-bit compares so a box near the right/bottom edge never wraps to column 0.
  always_comb begin
    x11   = {1'b0, bus.x};
    y11   = {1'b0, bus.y};
    l11   = {1'b0, pos_l};
    u11   = {1'b0, pos_u};
    hit   = (x11 >= l11) && (x11 < l11 + 11'(SPRITE_W)) &&
            (y11 >= u11) && (y11 < u11 + 11'(SPRITE_H));
    col   = x11 - l11;
    row   = y11 - u11;
    // The sheet is drawn facing right.
    col_m = (dir_l == LEFT_DIR) ? (11'(SPRITE_W - 1) - col) : col;
    addr  = sprite_addr(frame_idx, row, col_m);
  end

  assign opaque = hit_d2_q && (bus.rom_data != TRANSPARENT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_addr_q  <= '0;
      hit_d1_q    <= 1'b0;
      hit_d2_q    <= 1'b0;
      sprite_on_q <= 1'b0;
      pixel_q     <= '0;
    end else begin
      rom_addr_q  <= hit ? addr : 11'd0;
      hit_d1_q    <= hit;
      hit_d2_q    <= hit_d1_q;
      sprite_on_q <= opaque;
      pixel_q     <= opaque ? bus.rom_data : 12'd0;
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.sprite_on = sprite_on_q;
  assign bus.pixel_out = pixel_q;

endmodule

// File: tb/tb_people_sprite_render.sv
// Self-checking bench for people_sprite_render: constant vector table, hand-built animation,
// freeze, wrap and reset sequences, then random scans against a frame-level reference model.
module tb_people_sprite_render;

  localparam int unsigned ANIM_DIV   = 8;
  localparam int          FRAME_LINE = 480;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  people_sprite_render_if bus ();

  people_sprite_render #(
    .ANIM_DIV    (ANIM_DIV),
    .FRAME_LINE  (FRAME_LINE),
    .TRANSPARENT (12'h0F0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_fn(input logic [10:0] a);
    if (a % 11'd7 == 11'd3) return 12'h0F0;
    return {1'b1, a} ^ 12'h35C;
  endfunction

  // Synchronous sprite ROM, one clock of latency.
  always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: frame-level view of the player.
  int m_pl, m_pu, m_dir, m_frame, m_div;
  int g_pl = 320, g_pu = 240, g_dir = 0, g_frz = 0;
  bit hp1 = 0, hp2 = 0;
  int ap1 = 0, ap2 = 0;

  typedef struct {
    int x;
    int y;
    int exp;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pl = 320; m_pu = 240; m_dir = 0; m_frame = 0; m_div = 0;
  endfunction

  function automatic void model_fb(input int pl, input int pu, input int d, input int frz);
    bit moving;
    moving = (pl != m_pl) || (pu != m_pu);
    m_pl = pl; m_pu = pu; m_dir = d;
    if (frz == 0) begin
      if (!moving) begin
        m_frame = 0; m_div = 0;
      end else begin
        m_div = m_div + 1;
        if (m_div == ANIM_DIV) begin
          m_div = 0;
          m_frame = (m_frame + 1) % 4;
        end
      end
    end
  endfunction

  function automatic void model_pix(input int xx, input int yy, output bit h, output int a);
    int col, row;
    h = (xx >= m_pl) && (xx < m_pl + 20) && (yy >= m_pu) && (yy < m_pu + 20);
    a = 0;
    if (h) begin
      col = xx - m_pl;
      row = yy - m_pu;
      if (m_dir == 0) col = 19 - col;
      a = m_frame * 400 + row * 20 + col;
    end
  endfunction

  // One clock: drive a pixel, advance the model, check address now and output 3 clk back.
  task automatic tick(input int xx, input int yy, input bit pe, input bit rn);
    bit h, fb, exp_on;
    int a;
    logic [11:0] d;
    bus.x           = 10'(xx);
    bus.y           = 10'(yy);
    bus.pix_en      = pe;
    bus.people_left = 10'(g_pl);
    bus.people_up   = 10'(g_pu);
    bus.dir         = g_dir[0];
    bus.freeze      = g_frz[0];
    rst_n           = rn;
    fb = rn && pe && (xx == 0) && (yy == FRAME_LINE);
    if (rn) model_pix(xx, yy, h, a);
    else begin
      h = 0; a = 0;
    end
    @(posedge clk);
    #1;
    if (!rn) begin
      model_reset();
      hp1 = 0; hp2 = 0;
    end else if (fb) begin
      model_fb(g_pl, g_pu, g_dir, g_frz);
    end
    d      = rom_fn(11'(ap2));
    exp_on = hp2 && (d != 12'h0F0);
    check("rom_addr", bus.rom_addr, a);
    check("sprite_on", bus.sprite_on, exp_on);
    check("pixel_out", bus.pixel_out, exp_on ? d : 12'd0);
    hp2 = hp1; ap2 = ap1;
    hp1 = h;   ap1 = a;
  endtask

  task automatic frame_tick();
    tick(0, FRAME_LINE, 1'b1, 1'b1);
  endtask

  task automatic pix_check(input string name, input int xx, input int yy, input int exp);
    tick(xx, yy, 1'b1, 1'b1);
    check(name, bus.rom_addr, exp);
  endtask

  initial begin
    tbl[0] = '{99, 50, 0};
    tbl[1] = '{100, 50, 0};
    tbl[2] = '{101, 50, 1};
    tbl[3] = '{110, 50, 10};
    tbl[4] = '{119, 50, 19};
    tbl[5] = '{120, 50, 0};
    tbl[6] = '{105, 69, 385};
    tbl[7] = '{105, 70, 0};
    tbl[8] = '{105, 49, 0};
    tbl[9] = '{100, 51, 20};

    tick(0, 0, 1'b0, 1'b0);
    tick(0, 0, 1'b0, 1'b0);
    check("reset_rom_addr", bus.rom_addr, 0);
    check("reset_sprite_on", bus.sprite_on, 0);
    check("reset_pixel_out", bus.pixel_out, 0);

    // Facing right at (100,50): table of scan points.
    g_pl = 100; g_pu = 50; g_dir = 1; g_frz = 0;
    frame_tick();
    foreach (tbl[i]) pix_check("table_addr", tbl[i].x, tbl[i].y, tbl[i].exp);
    for (int i = 0; i < 4; i++) tick(0, 0, 1'b0, 1'b1);

    // Facing left: mirrored addresses.
    g_dir = 0;
    frame_tick();
    for (int xx = 100; xx < 120; xx++) pix_check("mirror_addr", xx, 50, 119 - xx);

    // Walk one pixel per frame: frame index steps every 8 frames and wraps after 32.
    g_dir = 1;
    for (int n = 1; n <= 40; n++) begin
      g_pl = 100 + n;
      frame_tick();
      pix_check("anim_frame", 100 + n, 50, ((n / 8) % 4) * 400);
    end
    frame_tick();
    pix_check("anim_hold", g_pl, 50, 0);

    // Freeze at frame 2 with div part-way, then resume from the held divider.
    for (int n = 0; n < 19; n++) begin
      g_pl++;
      frame_tick();
    end
    pix_check("pre_freeze", g_pl, 50, 800);
    g_frz = 1;
    for (int n = 0; n < 20; n++) begin
      g_pl++;
      frame_tick();
      pix_check("freeze_hold", g_pl, 50, 800);
    end
    g_frz = 0;
    for (int k = 1; k <= 5; k++) begin
      g_pl++;
      frame_tick();
      pix_check("freeze_resume", g_pl, 50, (k >= 5) ? 1200 : 800);
    end

    // Box at the right edge must not wrap onto column 0.
    g_pl = 1015; g_pu = 50; g_dir = 1;
    frame_tick();
    frame_tick();
    pix_check("edge_hit", 1020, 50, 5);
    pix_check("edge_nowrap", 3, 50, 0);
    pix_check("edge_last", 1023, 50, 8);
    pix_check("edge_before", 1014, 50, 0);

    // Reset in the middle of a scan inside the box.
    g_pl = 100; g_pu = 50; g_dir = 1;
    frame_tick();
    for (int xx = 100; xx < 106; xx++) tick(xx, 50, 1'b1, 1'b1);
    tick(106, 50, 1'b1, 1'b0);
    check("midscan_reset_sprite", bus.sprite_on, 0);
    pix_check("reset_latch_addr", 325, 245, 114);
    for (int i = 0; i < 4; i++) tick(0, 0, 1'b0, 1'b1);

    // Random scans around the current box with random frames, freezes and resets.
    for (int it = 0; it < 4000; it++) begin
      int r, xx, yy;
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        tick(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b1, 1'b0);
      end else if (r < 9) begin
        if ($urandom_range(0, 9) < 7) g_pl = (g_pl + 1) % 1024;
        if ($urandom_range(0, 9) < 2) g_pu = (g_pu + 1023) % 1024;
        if ($urandom_range(0, 19) == 0) g_pl = int'($urandom_range(0, 1023));
        g_dir = int'($urandom_range(0, 1));
        g_frz = ($urandom_range(0, 9) == 0) ? 1 : 0;
        frame_tick();
      end else begin
        xx = (m_pl + 1024 + int'($urandom_range(0, 27)) - 4) % 1024;
        yy = (m_pu + 1024 + int'($urandom_range(0, 27)) - 4) % 1024;
        tick(xx, yy, $urandom_range(0, 1) == 1, 1'b1);
      end
    end
    for (int i = 0; i < 4; i++) tick(0, 0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
